// File: rtl/pht_pkg.sv
// rtl/pht_pkg.sv - shared types, defaults and counter arithmetic for the PHT access controller
package pht_pkg;

    localparam int HIST_W_DEF = 8;
    localparam int PC_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_WR = 2'd2
    } pht_state_e;

    typedef logic [1:0] pht_ctr_t;

    // Two-bit saturating counter step: never wraps past strongly taken or strongly not-taken.
    function automatic pht_ctr_t ctr_sat_update(input pht_ctr_t old, input logic taken);
        pht_ctr_t res;
        if (taken) begin
            res = (old == 2'b11) ? old : old + 2'b01;
        end else begin
            res = (old == 2'b00) ? old : old - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/pht_access_ctrl_upd_fifo.sv
// rtl/pht_access_ctrl_upd_fifo.sv - synchronous update queue holding resolved branches awaiting their RMW
module pht_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Pointer and occupancy update; a push and pop in the same cycle leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/pht_access_ctrl.sv
// rtl/pht_access_ctrl.sv - gshare-style PHT arbiter: clear sweep, lookups, queued saturating updates
module pht_access_ctrl
    import pht_pkg::*;
#(
    parameter int HIST_W     = HIST_W_DEF,
    parameter int PC_W       = PC_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lk_valid,
    input  logic [PC_W-1:0]        lk_pc,
    output logic                   lk_ready,
    output logic                   pred_valid,
    output logic                   pred_taken,
    output logic [HIST_W-1:0]      pred_bhr,
    input  logic                   upd_valid,
    input  logic [PC_W-1:0]        upd_pc,
    input  logic [HIST_W-1:0]      upd_bhr,
    input  logic                   upd_taken,
    output logic                   upd_ready,
    output logic [HIST_W-1:0]      bhr,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [HIST_W+PC_W-1:0] mem_addr,
    output logic [1:0]             mem_wdata,
    input  logic [1:0]             mem_rdata,
    output logic                   clearing
);

    localparam int ADDR_W = HIST_W + PC_W;
    localparam int ENT_W  = PC_W + HIST_W + 1;

    pht_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [HIST_W-1:0]   bhr_q, bhr_d;
    logic                pred_valid_q, pred_valid_d;
    logic [HIST_W-1:0]   pred_bhr_q, pred_bhr_d;
    logic [ADDR_W-1:0]   rmw_addr_q, rmw_addr_d;
    logic                rmw_taken_q, rmw_taken_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic [ENT_W-1:0]    fifo_din;
    logic [ENT_W-1:0]    fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;

    logic [PC_W-1:0]     head_pc;
    logic [HIST_W-1:0]   head_bhr;
    logic                head_taken;
    logic                head_rd;
    logic                lk_fire;
    logic                upd_fire;

    // Queue entries are {pc, history, taken}; the head is unpacked for the RMW read.
    assign fifo_din   = {upd_pc, upd_bhr, upd_taken};
    assign head_pc    = fifo_dout[ENT_W-1 -: PC_W];
    assign head_bhr   = fifo_dout[HIST_W:1];
    assign head_taken = fifo_dout[0];

    assign clearing   = rst || (state_q == ST_CLEAR);
    assign upd_ready  = !clearing && !fifo_full;
    assign upd_fire   = upd_valid && upd_ready;
    assign fifo_push  = upd_fire;
    assign lk_fire    = lk_valid && lk_ready;

    assign bhr        = bhr_q;
    assign pred_valid = pred_valid_q;
    assign pred_bhr   = pred_bhr_q;
    assign pred_taken = pred_valid_q && mem_rdata[1];

    pht_upd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: sweep to the last address, then alternate IDLE and UPD_WR per update.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_addr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (head_rd) begin
                    state_d = ST_UPD_WR;
                end
            end
            ST_UPD_WR: state_d = ST_IDLE;
            default:   state_d = ST_CLEAR;
        endcase
    end

    // FSM outputs: one RAM access per cycle; lookups win unless the queue is full.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 2'b00;
        lk_ready  = 1'b0;
        fifo_pop  = 1'b0;
        head_rd   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_addr_q;
            end
            ST_IDLE: begin
                if (fifo_full) begin
                    head_rd = 1'b1;
                end else begin
                    lk_ready = 1'b1;
                    if (lk_valid) begin
                        mem_en   = 1'b1;
                        mem_addr = {bhr_q, lk_pc};
                    end else if (!fifo_empty) begin
                        head_rd = 1'b1;
                    end
                end
                if (head_rd) begin
                    mem_en   = 1'b1;
                    mem_addr = {head_bhr, head_pc};
                    fifo_pop = 1'b1;
                end
            end
            ST_UPD_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = rmw_addr_q;
                mem_wdata = ctr_sat_update(mem_rdata, rmw_taken_q);
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
        // Reset cancels any access still decoded from the old state, including a pending RMW write.
        if (rst) begin
            mem_en   = 1'b0;
            mem_we   = 1'b0;
            lk_ready = 1'b0;
            fifo_pop = 1'b0;
            head_rd  = 1'b0;
        end
    end

    // Datapath next values: sweep address, history shift, prediction tag and RMW target capture.
    always_comb begin
        clr_addr_d   = clr_addr_q;
        bhr_d        = bhr_q;
        pred_valid_d = lk_fire;
        pred_bhr_d   = pred_bhr_q;
        rmw_addr_d   = rmw_addr_q;
        rmw_taken_d  = rmw_taken_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
        if (upd_fire) begin
            bhr_d = {bhr_q[HIST_W-2:0], upd_taken};
        end
        if (lk_fire) begin
            pred_bhr_d = bhr_q;
        end
        if (head_rd) begin
            rmw_addr_d  = {head_bhr, head_pc};
            rmw_taken_d = head_taken;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr_q   <= '0;
            bhr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_bhr_q   <= '0;
            rmw_addr_q   <= '0;
            rmw_taken_q  <= 1'b0;
        end else begin
            clr_addr_q   <= clr_addr_d;
            bhr_q        <= bhr_d;
            pred_valid_q <= pred_valid_d;
            pred_bhr_q   <= pred_bhr_d;
            rmw_addr_q   <= rmw_addr_d;
            rmw_taken_q  <= rmw_taken_d;
        end
    end

endmodule

// File: tb/tb_pht_access_ctrl.sv
// tb/tb_pht_access_ctrl.sv - randomized and directed self-checking bench for pht_access_ctrl
module tb_pht_access_ctrl;

    localparam int HIST_W     = 8;
    localparam int PC_W       = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = HIST_W + PC_W;
    localparam int NUM_ENT    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              lk_valid = 1'b0;
    logic [PC_W-1:0]   lk_pc = '0;
    logic              lk_ready;
    logic              pred_valid;
    logic              pred_taken;
    logic [HIST_W-1:0] pred_bhr;
    logic              upd_valid = 1'b0;
    logic [PC_W-1:0]   upd_pc = '0;
    logic [HIST_W-1:0] upd_bhr = '0;
    logic              upd_taken = 1'b0;
    logic              upd_ready;
    logic [HIST_W-1:0] bhr;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_wdata;
    logic [1:0]        mem_rdata;
    logic              clearing;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] hb;
        logic              taken;
    } upd_t;

    logic [1:0]        ram     [NUM_ENT];
    logic [1:0]        ref_pht [NUM_ENT];
    logic [HIST_W-1:0] ref_bhr;
    upd_t              ref_q[$];
    logic [1:0]        wr_log[$];
    bit                mon_en = 1'b0;
    bit                pend = 1'b0;
    logic              pend_taken;
    logic [HIST_W-1:0] pend_bhr;

    always #5 clk = ~clk;

    pht_access_ctrl #(
        .HIST_W     (HIST_W),
        .PC_W       (PC_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lk_valid   (lk_valid),
        .lk_pc      (lk_pc),
        .lk_ready   (lk_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_bhr   (pred_bhr),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_bhr    (upd_bhr),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .bhr        (bhr),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .clearing   (clearing)
    );

    // Single-port PHT RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_sat(input logic [1:0] old, input logic tk);
        int v;
        v = int'(old) + (tk ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    // Reference model step for one sampled cycle.
    task automatic monitor();
        logic [ADDR_W-1:0] a;
        logic [1:0]        e;
        upd_t              h;
        bit                q_was_empty;
        if (!mon_en) return;
        q_was_empty = (ref_q.size() == 0);
        chk("bhr", bhr, ref_bhr);
        chk("pred_valid", pred_valid, pend);
        if (pend) begin
            chk("pred_taken", pred_taken, pend_taken);
            chk("pred_bhr", pred_bhr, pend_bhr);
        end
        pend = 1'b0;
        if (lk_valid && lk_ready) begin
            a = {ref_bhr, lk_pc};
            chk("lk_rd_en_we", {mem_en, mem_we}, 2'b10);
            chk("lk_rd_addr", mem_addr, a);
            pend       = 1'b1;
            pend_taken = ref_pht[a][1];
            pend_bhr   = ref_bhr;
        end else if (q_was_empty) begin
            chk("mem_idle", mem_en, 0);
        end
        if (mem_en && mem_we) begin
            if (ref_q.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                h = ref_q.pop_front();
                a = {h.hb, h.pc};
                e = ref_sat(ref_pht[a], h.taken);
                chk("wr_addr", mem_addr, a);
                chk("wr_data", mem_wdata, e);
                ref_pht[a] = e;
                wr_log.push_back(mem_wdata);
            end
        end
        chk("lk_ready_when_full", lk_ready && (ref_q.size() >= FIFO_DEPTH), 0);
        if (ref_q.size() < FIFO_DEPTH) chk("upd_ready", upd_ready, 1);
        if (upd_valid && upd_ready) begin
            ref_q.push_back('{upd_pc, upd_bhr, upd_taken});
            ref_bhr = {ref_bhr[HIST_W-2:0], upd_taken};
        end
    endtask

    task automatic clk_in();
        @(posedge clk);
        #1;
    endtask

    task automatic clk_out();
        @(negedge clk);
        monitor();
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (ref_q.size() != 0 || pend); i++) begin
            clk_in();
            clk_out();
        end
        chk("drain", ref_q.size(), 0);
    endtask

    task automatic push_upd(input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] hb, input logic tk);
        clk_in();
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_bhr   = hb;
        upd_taken = tk;
        clk_out();
        for (int i = 0; i < 20 && !upd_ready; i++) begin
            clk_in();
            clk_out();
        end
        chk("push_accept", upd_ready, 1);
        clk_in();
        upd_valid = 1'b0;
        clk_out();
    endtask

    task automatic lookup(input logic [PC_W-1:0] pc, input string tag, input logic [ADDR_W-1:0] exp_addr,
                          input logic exp_taken, input logic [HIST_W-1:0] exp_bhr);
        clk_in();
        lk_valid = 1'b1;
        lk_pc    = pc;
        clk_out();
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_rd"}, {mem_en, mem_we}, 2'b10);
        clk_in();
        lk_valid = 1'b0;
        clk_out();
        chk({tag, "_pred_valid"}, pred_valid, 1);
        chk({tag, "_pred_taken"}, pred_taken, exp_taken);
        chk({tag, "_pred_bhr"}, pred_bhr, exp_bhr);
    endtask

    // Continuous lookups while four updates arrive: the queue fills and the head RMW takes over.
    task automatic fill_and_rmw(input logic force_taken);
        clk_in();
        lk_valid = 1'b1;
        lk_pc    = 8'h21;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1;
            upd_pc    = 8'($urandom);
            upd_bhr   = 8'($urandom);
            upd_taken = force_taken | 1'($urandom);
            clk_out();
            chk("fill_push_ready", upd_ready, 1);
            chk("fill_lk_ready", lk_ready, 1);
            clk_in();
        end
        upd_valid = 1'b0;
        clk_out();
        chk("full_lk_ready", lk_ready, 0);
        chk("full_head_rd", {mem_en, mem_we}, 2'b10);
    endtask

    initial begin
        int cnt;
        int clr_bad;
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b11; exp_seq[3] = 2'b11;

        // Reset state.
        clk_in();
        clk_out();
        chk("rst_clearing", clearing, 1);
        chk("rst_mem_en_we", {mem_en, mem_we}, 0);
        chk("rst_pred", {pred_valid, pred_taken}, 0);
        chk("rst_pred_bhr", pred_bhr, 0);
        chk("rst_bhr", bhr, 0);
        chk("rst_ready", {lk_ready, upd_ready}, 0);

        // Full clear sweep.
        cnt = 0;
        clr_bad = 0;
        clk_in();
        rst = 1'b0;
        clk_out();
        while (clearing && cnt < 70000) begin
            if (!(mem_en && mem_we && mem_addr == ADDR_W'(cnt) && mem_wdata == 2'b00)) clr_bad++;
            cnt++;
            clk_in();
            clk_out();
        end
        chk("clear_cycles", cnt, NUM_ENT);
        chk("clear_sequence", clr_bad, 0);
        chk("ready_after_clear", {lk_ready, upd_ready}, 2'b11);
        chk("idle_mem_en", mem_en, 0);

        for (int i = 0; i < NUM_ENT; i++) ref_pht[i] = 2'b00;
        ref_bhr = '0;
        ref_q.delete();
        wr_log.delete();
        pend   = 1'b0;
        mon_en = 1'b1;

        // First lookup after clear.
        lookup(8'h12, "first_lookup", 16'h0012, 1'b0, 8'h00);

        // Four taken updates on one entry, then history walked back to zero.
        wr_log.delete();
        for (int i = 0; i < 4; i++) push_upd(8'h12, 8'h00, 1'b1);
        drain();
        chk("sat_up_count", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++) chk("sat_up_seq", wr_log[i], exp_seq[i]);
        chk("bhr_after_taken", bhr, 8'h0F);
        for (int i = 0; i < 8; i++) push_upd(8'h55, 8'h0F, 1'b0);
        drain();
        chk("bhr_after_not_taken", bhr, 8'h00);
        lookup(8'h12, "strong_lookup", 16'h0012, 1'b1, 8'h00);

        // Saturation limits.
        wr_log.delete();
        push_upd(8'h12, 8'h00, 1'b1);
        push_upd(8'h33, 8'h44, 1'b0);
        drain();
        chk("sat_limit_count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("sat_high_hold", wr_log[0], 2'b11);
            chk("sat_low_hold", wr_log[1], 2'b00);
        end

        // Starvation guard.
        fill_and_rmw(1'b0);
        clk_in();
        clk_out();
        chk("rmw_wr_lk_ready", lk_ready, 0);
        chk("rmw_wr_en_we", {mem_en, mem_we}, 2'b11);
        clk_in();
        clk_out();
        chk("rmw_done_lk_ready", lk_ready, 1);
        clk_in();
        lk_valid = 1'b0;
        clk_out();
        drain();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            clk_in();
            lk_valid  = ($urandom % 4) != 0;
            lk_pc     = 8'($urandom_range(16, 19));
            upd_valid = ($urandom % 3) == 0;
            upd_pc    = 8'($urandom_range(16, 19));
            upd_bhr   = ($urandom % 2) ? ref_bhr : 8'($urandom);
            upd_taken = 1'($urandom);
            clk_out();
        end
        clk_in();
        lk_valid  = 1'b0;
        upd_valid = 1'b0;
        clk_out();
        drain();

        // Reset landing on an in-flight RMW with three entries still queued.
        fill_and_rmw(1'b1);
        clk_in();
        mon_en   = 1'b0;
        rst      = 1'b1;
        lk_valid = 1'b0;
        clk_out();
        chk("rst_rmw_no_write", {mem_en, mem_we}, 0);
        chk("rst_rmw_clearing", clearing, 1);
        clk_in();
        clk_out();
        chk("rst_fifo_empty", dut.fifo_empty, 1);
        chk("rst_bhr_zero", bhr, 0);
        chk("rst_pred_valid", pred_valid, 0);
        clk_in();
        rst = 1'b0;
        clk_out();
        for (int i = 0; i < 4; i++) begin
            chk("restart_addr", mem_addr, i);
            chk("restart_en_we", {mem_en, mem_we, clearing}, 3'b111);
            clk_in();
            clk_out();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pht_access_ctrl.md
PHT_ACCESS_CTRL -- requirements
Module: pht_access_ctrl

Interface
REQ-001 The block SHALL have parameter HIST_W, default 8, global branch-history width.
REQ-002 The block SHALL have parameter PC_W, default 8, PC index bits (PC[9:2]).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, update-queue entries (power of two).
REQ-004 The block SHALL have port clk, input, 1, clock, all logic on rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 The block SHALL have ports lk_valid in 1, lk_pc in PC_W, lk_ready out 1: the prediction lookup request.
REQ-007 The block SHALL have ports pred_valid out 1, pred_taken out 1, pred_bhr out HIST_W: the lookup result and the history used to produce it.
REQ-008 The block SHALL have ports upd_valid in 1, upd_pc in PC_W, upd_bhr in HIST_W, upd_taken in 1, upd_ready out 1: the resolved-branch update.
REQ-009 The block SHALL have port bhr, output, HIST_W: the current global history.
REQ-010 The block SHALL have ports mem_en out 1, mem_we out 1, mem_addr out HIST_W+PC_W, mem_wdata out 2, mem_rdata in 2 to a single-port PHT RAM with 1-cycle read latency.
REQ-011 The block SHALL have port clearing, output, 1: high while the PHT initialisation sweep runs.

Function
REQ-012 The PHT address SHALL be {history, pc}, with history in the high bits.
REQ-013 The FSM SHALL have states CLEAR, IDLE and UPD_WR, and exactly one RAM access (at most) SHALL be issued per cycle.
REQ-014 In CLEAR the block SHALL write 2'b00 to sequential addresses 0..2^(HIST_W+PC_W)-1, one per cycle, hold lk_ready=0 and upd_ready=0, and enter IDLE the cycle after the last address is written.
REQ-015 An update SHALL be accepted on upd_valid&&upd_ready, pushing {upd_pc, upd_bhr, upd_taken} into the FIFO; upd_ready = !clearing && FIFO not full.
REQ-016 On update accept, bhr SHALL become {bhr[HIST_W-2:0], upd_taken} on the next cycle.
REQ-017 In IDLE, when the FIFO is not full, lk_ready SHALL be 1 and a lookup SHALL have priority over a queued update.
REQ-018 When the FIFO is full, the head update SHALL win and lk_ready SHALL be 0 (starvation guard).
REQ-019 A lookup accepted in cycle N SHALL issue a read of {bhr, lk_pc}; in cycle N+1, pred_valid=1, pred_taken=mem_rdata[1] and pred_bhr = bhr as sampled at N. Back-to-back lookups SHALL sustain 1 per cycle.
REQ-020 An update SHALL be a read-modify-write: in IDLE, pop the head and read {upd_bhr, upd_pc}; in UPD_WR, write the saturated value and return to IDLE. lk_ready SHALL be 0 in UPD_WR.
REQ-021 Saturation SHALL be: taken gives min(old+1, 3); not-taken gives max(old-1, 0); 2-bit arithmetic SHALL never wrap.
REQ-022 A lookup to an address with an update in flight SHALL return the pre-write value; no forwarding is performed.
REQ-023 A simultaneous FIFO push and pop SHALL both occur, leaving the occupancy unchanged.
REQ-024 When neither a lookup nor an update is served, mem_en SHALL be 0.

Reset
REQ-025 On rst the block SHALL enter CLEAR at address 0.
REQ-026 On rst the following SHALL be cleared: FIFO empty, bhr=0, pred_valid=0, pred_taken=0, pred_bhr=0, mem_en=0, mem_we=0, clearing=1.
REQ-027 rst asserted mid-operation SHALL discard any in-flight read-modify-write and any queued updates, and SHALL restart the sweep from address 0.

Structure
REQ-028 Package pht_pkg SHALL hold HIST_W/PC_W defaults, the FSM state enum, the 2-bit counter typedef, and the saturating-increment/decrement function.
REQ-029 The update queue SHALL be a sub-module pht_upd_fifo (synchronous FIFO with full/empty and parameterised depth and width).

Verification
REQ-030 Bench scenario: rst pulse, then no traffic: clearing=1 for exactly 65536 cycles, each address written with 00, then lk_ready=1.
REQ-031 Bench scenario: after clear, lookup lk_pc=0x12 with bhr=0: mem_addr=0x0012 read, next cycle pred_valid=1, pred_taken=0, pred_bhr=0x00.
REQ-032 Bench scenario: four taken updates for pc=0x12, bhr=0x00 (no lookups): entry goes 00 to 01, 10, 11, 11; bhr=0x0F; a later lookup at 0x0012 gives pred_taken=1 once bhr is forced back to 0x00 by eight not-taken updates elsewhere.
REQ-033 Bench scenario: with a continuous lk_valid stream and 4 updates pushed, the FIFO fills, lk_ready drops to 0, and the head update completes its read-modify-write in 2 cycles, after which lk_ready returns to 1.
REQ-034 Bench scenario: a not-taken update on an entry at 00 leaves it at 00, and a taken update on an entry at 11 leaves it at 11.
REQ-035 Bench scenario: rst asserted in UPD_WR with 3 entries queued: no write of the pending value occurs, the FIFO is empty, bhr=0, and CLEAR restarts at address 0.
